// File: rtl/wb_master_iface.sv
// wb_master_iface: single-transfer Wishbone classic master with registered request fields.
// Optional macro WB_MASTER_RETRY_EN: reissue on wb_rty_i up to MAX_RETRY times.
`default_nettype none

module wb_master_iface #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            start,
  input  logic [AW-1:0]   address,
  input  logic [DW/8-1:0] selection,
  input  logic            write,
  input  logic [DW-1:0]   data_wr,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  output logic [DW-1:0]   data_rd,
  output logic            active
);

  if (MAX_RETRY < 0 || (DW % 8) != 0) begin : g_bad_params
    $error("wb_master_iface: MAX_RETRY must be >= 0 and DW a multiple of 8");
  end

`ifdef WB_MASTER_RETRY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, WAIT = 2'd2} state_t;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry;
  logic          w_retry;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;
`endif

  state_t r_state, w_next;
  logic   w_end;
  logic   w_capture;

  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Termination priority inside BUS: err, then rty, then ack.
  always_comb begin
    w_next    = r_state;
    w_end     = 1'b0;
    w_capture = 1'b0;
`ifdef WB_MASTER_RETRY_EN
    w_retry   = 1'b0;
`endif
    case (r_state)
      IDLE: if (start) w_next = BUS;
      BUS: begin
        if (wb_err_i) begin
          w_next = IDLE;
          w_end  = 1'b1;
        end else if (wb_rty_i) begin
`ifdef WB_MASTER_RETRY_EN
          if (r_retry < RW'(MAX_RETRY)) begin
            w_next  = WAIT;
            w_retry = 1'b1;
          end else begin
            w_next = IDLE;
            w_end  = 1'b1;
          end
`else
          w_next = IDLE;
          w_end  = 1'b1;
`endif
        end else if (wb_ack_i) begin
          w_next    = IDLE;
          w_end     = 1'b1;
          w_capture = !wb_we_o;
        end
      end
`ifdef WB_MASTER_RETRY_EN
      WAIT:    w_next = BUS;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      data_rd  <= '0;
      active   <= 1'b0;
`ifdef WB_MASTER_RETRY_EN
      r_retry  <= '0;
`endif
    end else begin
      // cyc/stb track BUS exactly; active also covers the retry gap.
      wb_cyc_o <= (w_next == BUS);
      wb_stb_o <= (w_next == BUS);
      active   <= (w_next != IDLE);
      if (r_state == IDLE && start) begin
        wb_adr_o <= address;
        wb_dat_o <= data_wr;
        wb_sel_o <= selection;
        wb_we_o  <= write;
`ifdef WB_MASTER_RETRY_EN
        r_retry  <= '0;
`endif
      end
      if (w_end)     wb_we_o <= 1'b0;
      if (w_capture) data_rd <= wb_dat_i;
`ifdef WB_MASTER_RETRY_EN
      if (w_retry)   r_retry <= r_retry + 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_iface.sv
// Directed self-checking bench for wb_master_iface; the bench plays the Wishbone slave.
`default_nettype none

module tb_wb_master_iface;
  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  selection = '0;
  logic        write = 1'b0;
  logic [31:0] data_wr = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, data_rd;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, active;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_adr [4] = '{32'h2000_0004, 32'h3000_0000, 32'h9000_0000, 32'hA000_0000};
  logic [31:0] m_dat [4] = '{32'h0123_4567, 32'h1A1A_1B1B, 32'h2A2A_2B2B, 32'h3A3A_3B3B};
  int          rd_order [4] = '{2, 1, 0, 3};

  wb_master_iface #(.AW(32), .DW(32), .MAX_RETRY(3)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .data_rd(data_rd), .active(active)
  );

  always #5 wb_clk = ~wb_clk;

  // Called at a negedge; pulses start for one edge, then scrambles the request inputs.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
    address = a; selection = s; write = w; data_wr = d; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0; address = ~a; selection = ~s; write = ~w; data_wr = ~d;
  endtask

  // Called at a negedge; presents terminations for one edge, slave memory updated on ack.
  task automatic terminate(input logic ack, input logic err, input logic rty);
    if (!wb_we_o) wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'hDEAD_BEEF;
    if (ack && !err && !rty && wb_we_o) mem[wb_adr_o] = wb_dat_o;
    wb_ack_i = ack; wb_err_i = err; wb_rty_i = rty;
    @(negedge wb_clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0BAD_0BAD;
  endtask

  task automatic test_reset;
    #1 wb_rst = 1'b0;
    #1;
    n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, active} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b exp 0000", {wb_cyc_o, wb_stb_o, wb_we_o, active}); end
    n_checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin n_fail++; $display("FAIL rst_fields: got %h exp 0", {wb_adr_o, wb_dat_o, wb_sel_o}); end
    n_checks++; if (data_rd !== 32'h0) begin n_fail++; $display("FAIL rst_data_rd: got %h exp 0", data_rd); end
    n_checks++; if ({wb_cti_o, wb_bte_o} !== 5'b0) begin n_fail++; $display("FAIL cti_bte: got %b exp 00000", {wb_cti_o, wb_bte_o}); end
    start = 1'b1;
    @(negedge wb_clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_start_ignored: got %b exp 0", active); end
    start = 1'b0;
    wb_rst = 1'b1;
  endtask

  task automatic test_write_read;
    issue(32'h2000_0000, 4'hF, 1'b1, 32'hA5A5_B6B6);
    n_checks++; if ({wb_cyc_o, wb_stb_o, active} !== 3'b111) begin n_fail++; $display("FAIL wr_ctrl: got %b exp 111", {wb_cyc_o, wb_stb_o, active}); end
    n_checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {32'h2000_0000, 32'hA5A5_B6B6, 4'hF, 1'b1}) begin
      n_fail++; $display("FAIL wr_fields: got %h exp %h", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}, {32'h2000_0000, 32'hA5A5_B6B6, 4'hF, 1'b1}); end
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, active} !== 4'b0) begin n_fail++; $display("FAIL wr_end: got %b exp 0000", {wb_cyc_o, wb_stb_o, wb_we_o, active}); end
    n_checks++; if (data_rd !== 32'h0) begin n_fail++; $display("FAIL wr_keeps_data_rd: got %h exp 0", data_rd); end
    issue(32'h2000_0000, 4'hF, 1'b0, 32'h0);
    n_checks++; if ({wb_cyc_o, wb_we_o} !== 2'b10) begin n_fail++; $display("FAIL rd_ctrl: got %b exp 10", {wb_cyc_o, wb_we_o}); end
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if ({data_rd, active, wb_cyc_o} !== {32'hA5A5_B6B6, 2'b00}) begin n_fail++; $display("FAIL rd_data: got %h exp %h", {data_rd, active, wb_cyc_o}, {32'hA5A5_B6B6, 2'b00}); end
  endtask

  task automatic test_hold;
    issue(32'h2000_0000, 4'hF, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      n_checks++; if ({wb_cyc_o, wb_stb_o, active, wb_adr_o} !== {3'b111, 32'h2000_0000}) begin
        n_fail++; $display("FAIL hold_%0d: got %h exp %h", i, {wb_cyc_o, wb_stb_o, active, wb_adr_o}, {3'b111, 32'h2000_0000}); end
    end
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if (data_rd !== 32'hA5A5_B6B6) begin n_fail++; $display("FAIL hold_data: got %h exp A5A5B6B6", data_rd); end
  endtask

  task automatic test_multi;
    for (int i = 0; i < 4; i++) begin
      issue(m_adr[i], 4'hF, 1'b1, m_dat[i]);
      terminate(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(m_adr[rd_order[i]], 4'hF, 1'b0, 32'h0);
      terminate(1'b1, 1'b0, 1'b0);
      n_checks++; if (data_rd !== m_dat[rd_order[i]]) begin n_fail++; $display("FAIL multi_rd_%0d: got %h exp %h", i, data_rd, m_dat[rd_order[i]]); end
    end
  endtask

  task automatic test_err;
    issue(32'h9000_0000, 4'hF, 1'b0, 32'h0);
    terminate(1'b0, 1'b1, 1'b0);
    n_checks++; if ({data_rd, wb_cyc_o, active} !== {32'h3A3A_3B3B, 2'b00}) begin n_fail++; $display("FAIL err_rd: got %h exp %h", {data_rd, wb_cyc_o, active}, {32'h3A3A_3B3B, 2'b00}); end
    issue(32'h3000_0000, 4'hF, 1'b0, 32'h0);
    terminate(1'b1, 1'b1, 1'b1);
    n_checks++; if ({data_rd, wb_cyc_o, active} !== {32'h3A3A_3B3B, 2'b00}) begin n_fail++; $display("FAIL err_prio: got %h exp %h", {data_rd, wb_cyc_o, active}, {32'h3A3A_3B3B, 2'b00}); end
  endtask

  task automatic test_ignore;
    issue(32'h4000_0000, 4'h3, 1'b1, 32'h55AA_55AA);
    address = $urandom; data_wr = $urandom; selection = 4'hC; write = 1'b0; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    n_checks++; if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {2'b11, 4'h3, 32'h4000_0000, 32'h55AA_55AA}) begin
      n_fail++; $display("FAIL ignore_fields: got %h exp %h", {wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, {2'b11, 4'h3, 32'h4000_0000, 32'h55AA_55AA}); end
    terminate(1'b1, 1'b0, 1'b0);
    issue(32'h4000_0000, 4'hF, 1'b0, 32'h0);
    n_checks++; if ({wb_cyc_o, active, wb_we_o, wb_adr_o} !== {3'b110, 32'h4000_0000}) begin
      n_fail++; $display("FAIL b2b_accept: got %h exp %h", {wb_cyc_o, active, wb_we_o, wb_adr_o}, {3'b110, 32'h4000_0000}); end
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if (data_rd !== 32'h55AA_55AA) begin n_fail++; $display("FAIL b2b_data: got %h exp 55AA55AA", data_rd); end
  endtask

  task automatic test_retry;
    issue(32'h2000_0000, 4'hF, 1'b1, 32'h1122_3344);
`ifdef WB_MASTER_RETRY_EN
    for (int k = 0; k < 2; k++) begin
      terminate(1'b0, 1'b0, 1'b1);
      n_checks++; if ({wb_cyc_o, wb_stb_o, active} !== 3'b001) begin n_fail++; $display("FAIL rty_gap_%0d: got %b exp 001", k, {wb_cyc_o, wb_stb_o, active}); end
      @(negedge wb_clk);
      n_checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== {2'b11, 32'h2000_0000, 32'h1122_3344}) begin
        n_fail++; $display("FAIL rty_reissue_%0d: got %h exp %h", k, {wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o}, {2'b11, 32'h2000_0000, 32'h1122_3344}); end
    end
    terminate(1'b1, 1'b0, 1'b0);
    issue(32'h2000_0000, 4'hF, 1'b0, 32'h0);
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if (data_rd !== 32'h1122_3344) begin n_fail++; $display("FAIL rty_readback: got %h exp 11223344", data_rd); end
    issue(32'h5000_0000, 4'hF, 1'b1, 32'h0000_0001);
    for (int k = 0; k < 3; k++) begin
      terminate(1'b0, 1'b0, 1'b1);
      @(negedge wb_clk);
    end
    terminate(1'b0, 1'b0, 1'b1);
    n_checks++; if ({wb_cyc_o, active} !== 2'b00) begin n_fail++; $display("FAIL rty_exhaust: got %b exp 00", {wb_cyc_o, active}); end
`else
    terminate(1'b0, 1'b0, 1'b1);
    n_checks++; if ({wb_cyc_o, wb_stb_o, active} !== 3'b000) begin n_fail++; $display("FAIL rty_as_err: got %b exp 000", {wb_cyc_o, wb_stb_o, active}); end
    @(negedge wb_clk);
    n_checks++; if ({wb_cyc_o, active} !== 2'b00) begin n_fail++; $display("FAIL rty_no_reissue: got %b exp 00", {wb_cyc_o, active}); end
    issue(32'h2000_0000, 4'hF, 1'b0, 32'h0);
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if (data_rd !== 32'hA5A5_B6B6) begin n_fail++; $display("FAIL rty_readback: got %h exp A5A5B6B6", data_rd); end
`endif
  endtask

  task automatic test_reset_mid;
    issue(32'h3000_0000, 4'hF, 1'b0, 32'h0);
    #2 wb_rst = 1'b0;
    #1;
    n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, active, wb_adr_o, wb_dat_o, wb_sel_o, data_rd} !== 104'h0) begin
      n_fail++; $display("FAIL rst_mid: got %h exp 0", {wb_cyc_o, wb_stb_o, wb_we_o, active, wb_adr_o, wb_dat_o, wb_sel_o, data_rd}); end
    @(negedge wb_clk);
    wb_rst = 1'b1;
    issue(32'h3000_0000, 4'hF, 1'b0, 32'h0);
    n_checks++; if ({wb_cyc_o, active} !== 2'b11) begin n_fail++; $display("FAIL rst_recover_ctrl: got %b exp 11", {wb_cyc_o, active}); end
    terminate(1'b1, 1'b0, 1'b0);
    n_checks++; if ({data_rd, active} !== {32'h1A1A_1B1B, 1'b0}) begin n_fail++; $display("FAIL rst_recover_data: got %h exp %h", {data_rd, active}, {32'h1A1A_1B1B, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_multi();
    test_err();
    test_ignore();
    test_retry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
